// File: rtl/axi_mem_resp_pkg.sv
// Shared types and constants for the AXI4 memory responder.
// Holds the response codes and the write- and read-channel state encodings.
package axi_mem_resp_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/axi_mem_resp_ram.sv
// Word storage for the AXI4 memory responder.
// Ports:
//   clk_i      clock for the write port
//   we_i       write enable
//   waddr_i    write word index
//   wdata_i    write word
//   raddr_i    read word index
//   rdata_c_o  read word (combinational, returns pre-write contents)
// Contents are not reset.
module axi_mem_resp_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_c_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Single synchronous write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read port.
    assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 memory responder: stores INCR write bursts in a word array and
// returns INCR read bursts from it. Write and read channels are independent
// FSMs with one outstanding transaction each.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   awvalid_i/awready_o, awaddr_i     write address channel
//   wvalid_i/wready_o, wdata_i, wlast_i  write data channel
//   bvalid_o/bready_i, bresp_o        write response channel
//   arvalid_i/arready_o, araddr_i, arlen_i  read address channel
//   rvalid_o/rready_i, rdata_o, rresp_o, rlast_o  read data channel
// Optional feature: AXI_MEM_RESP_ERR_EN replaces index wrap with a range
// check; out-of-range beats are dropped (write) or read as zero, and answered
// with SLVERR. Without it addresses alias modulo DEPTH and responses are OKAY.
module axi_mem_responder
    import axi_mem_resp_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              awvalid_i,
    output logic              awready_o,
    input  logic [ADDR_W-1:0] awaddr_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              wlast_i,
    output logic              bvalid_o,
    input  logic              bready_i,
    output logic [1:0]        bresp_o,
    input  logic              arvalid_i,
    output logic              arready_o,
    input  logic [ADDR_W-1:0] araddr_i,
    input  logic [7:0]        arlen_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        rresp_o,
    output logic              rlast_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned LEN_W = 8;
`ifdef AXI_MEM_RESP_ERR_EN
    // Keep the full word offset so out-of-range beats can be detected.
    localparam int unsigned OFS_W = ADDR_W - 2;
`else
    // Only the index bits matter; the offset wraps modulo DEPTH.
    localparam int unsigned OFS_W = IDX_W;
`endif

    // Byte offsets relative to the base; low two bits are ignored.
    logic [ADDR_W-1:0] aw_diff;
    logic [ADDR_W-1:0] ar_diff;
    assign aw_diff = awaddr_i - BASE_ADDR;
    assign ar_diff = araddr_i - BASE_ADDR;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{aw_diff, ar_diff};

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    w_state_e          w_state_q, w_state_d;
    logic [OFS_W-1:0]  w_ofs_q, w_ofs_d;
    logic              w_err_q, w_err_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              aw_hs, w_hs, b_hs;
    logic              w_in_range;
    logic              mem_we;

    assign aw_hs = awvalid_i & awready_q;
    assign w_hs  = wvalid_i & wready_q;
    assign b_hs  = bready_i & bvalid_q;

`ifdef AXI_MEM_RESP_ERR_EN
    assign w_in_range = (w_ofs_q < OFS_W'(DEPTH));
`else
    assign w_in_range = 1'b1;
`endif

    // No array writes while reset is asserted, even if wready was still high.
    assign mem_we = w_hs & w_in_range & ~rst_i;

    // Write next-state and registered-output logic.
    always_comb begin
        w_state_d = w_state_q;
        w_ofs_d   = w_ofs_q;
        w_err_d   = w_err_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    w_ofs_d   = aw_diff[OFS_W+1:2];
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    w_ofs_d = w_ofs_q + OFS_W'(1);
                    w_err_d = w_err_q | ~w_in_range;
                    if (wlast_i) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
        bresp_d   = (bvalid_d && w_err_d) ? RESP_SLVERR : RESP_OKAY;
    end

    // Write state and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
            w_ofs_q   <= '0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            w_ofs_q   <= w_ofs_d;
            w_err_q   <= w_err_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    r_state_e          r_state_q, r_state_d;
    logic [OFS_W-1:0]  r_ofs_q, r_ofs_d;
    logic [LEN_W-1:0]  r_cnt_q, r_cnt_d;
    logic              r_load;
    logic              r_in_range;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DATA_W-1:0] ram_rdata;
    logic              ar_hs, r_hs;

    assign ar_hs = arvalid_i & arready_q;
    assign r_hs  = rready_i & rvalid_q;

`ifdef AXI_MEM_RESP_ERR_EN
    assign r_in_range = (r_ofs_d < OFS_W'(DEPTH));
`else
    assign r_in_range = 1'b1;
`endif

    // Read next-state; a new beat is loaded from the array whenever r_load.
    always_comb begin
        r_state_d = r_state_q;
        r_ofs_d   = r_ofs_q;
        r_cnt_d   = r_cnt_q;
        r_load    = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_ofs_d   = ar_diff[OFS_W+1:2];
                    r_cnt_d   = arlen_i;
                    r_load    = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (r_cnt_q == LEN_W'(0)) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_ofs_d = r_ofs_q + OFS_W'(1);
                        r_cnt_d = r_cnt_q - LEN_W'(1);
                        r_load  = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
        rlast_d   = rvalid_d && (r_cnt_d == LEN_W'(0));
        // Hold the presented beat while stalled; clear when idle.
        if (r_load) begin
            rdata_d = r_in_range ? ram_rdata : '0;
            rresp_d = r_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_d) begin
            rdata_d = rdata_q;
            rresp_d = rresp_q;
        end else begin
            rdata_d = '0;
            rresp_d = RESP_OKAY;
        end
    end

    // Read state and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= R_IDLE;
            r_ofs_q   <= '0;
            r_cnt_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            r_ofs_q   <= r_ofs_d;
            r_cnt_q   <= r_cnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    axi_mem_resp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk_i     (clk_i),
        .we_i      (mem_we),
        .waddr_i   (w_ofs_q[IDX_W-1:0]),
        .wdata_i   (wdata_i),
        .raddr_i   (r_ofs_d[IDX_W-1:0]),
        .rdata_c_o (ram_rdata)
    );

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;
    assign arready_o = arready_q;
    assign rvalid_o  = rvalid_q;
    assign rlast_o   = rlast_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized self-checking bench for axi_mem_responder against a word-array
// reference model of the memory and its response rules.
module tb_axi_mem_responder;

    localparam int unsigned DEPTH  = 256;
    localparam logic [31:0] BASE   = 32'h0;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awvalid = 1'b0, awready;
    logic [31:0] awaddr = '0;
    logic        wvalid = 1'b0, wready, wlast = 1'b0;
    logic [31:0] wdata = '0;
    logic        bvalid, bready = 1'b0;
    logic [1:0]  bresp;
    logic        arvalid = 1'b0, arready;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic        rvalid, rready = 1'b0, rlast;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    always #5 clk = ~clk;

    axi_mem_responder #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr),
        .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wlast_i(wlast),
        .bvalid_o(bvalid), .bready_i(bready), .bresp_o(bresp),
        .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr), .arlen_i(arlen),
        .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rresp_o(rresp),
        .rlast_o(rlast)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] last_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Word index of beat n of a burst; returns 0 when the beat is out of range.
    function automatic bit beat_word(input logic [31:0] addr, input int beat, output int idx);
        longint unsigned ofs;
        ofs = 64'((addr - BASE) >> 2) + 64'(beat);
        idx = int'(ofs % DEPTH);
`ifdef AXI_MEM_RESP_ERR_EN
        return ofs < DEPTH;
`else
        return 1'b1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input int n, input logic [31:0] data[$]);
        int t;
        int idx;
        bit any_oob;
        awaddr  = addr;
        awvalid = 1'b1;
        t = 0;
        while (awready !== 1'b1 && t < 50) begin tick(); t++; end
        chk("aw_wait", 32'(t < 50), 32'd1);
        tick();
        awvalid = 1'b0;
        chk("aw_to_wready", 32'({awready, wready}), 32'b01);
        any_oob = 1'b0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3) == 0) begin
                wvalid = 1'b0;
                tick();
            end
            wvalid = 1'b1;
            wdata  = data[i];
            wlast  = (i == n - 1);
            chk("wready", 32'(wready), 32'd1);
            tick();
            if (beat_word(addr, i, idx)) model_mem[idx] = data[i];
            else any_oob = 1'b1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        chk("last_w_to_bvalid", 32'({wready, bvalid}), 32'b01);
        chk("bresp", 32'(bresp), 32'(any_oob ? SLVERR : OKAY));
        repeat ($urandom_range(2)) begin
            tick();
            chk("bvalid_hold", 32'(bvalid), 32'd1);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("b_to_awready", 32'({awready, bvalid}), 32'b10);
    endtask

    // mode 0: rready held high, 1: pattern 1,0,0 repeating, 2: random.
    task automatic do_read(input logic [31:0] addr, input int len, input int mode);
        logic [31:0] exp_d[$];
        logic [1:0]  exp_r[$];
        int idx, i, cyc, t, p;
        for (int k = 0; k <= len; k++) begin
            if (beat_word(addr, k, idx)) begin
                exp_d.push_back(model_mem[idx]);
                exp_r.push_back(OKAY);
            end else begin
                exp_d.push_back(32'h0);
                exp_r.push_back(SLVERR);
            end
        end
        araddr  = addr;
        arlen   = 8'(len);
        arvalid = 1'b1;
        t = 0;
        while (arready !== 1'b1 && t < 50) begin tick(); t++; end
        chk("ar_wait", 32'(t < 50), 32'd1);
        tick();
        arvalid = 1'b0;
        chk("ar_to_rvalid", 32'({arready, rvalid}), 32'b01);
        i = 0; cyc = 0; p = 0;
        while (i <= len && cyc < 2000) begin
            case (mode)
                0:       rready = 1'b1;
                1:       rready = (p % 3 == 0);
                default: rready = 1'($urandom_range(1));
            endcase
            p++;
            chk("rvalid", 32'(rvalid), 32'd1);
            chk("rdata", rdata, exp_d[i]);
            chk("rlast", 32'(rlast), 32'(i == len));
            chk("rresp", 32'(rresp), 32'(exp_r[i]));
            if (rready) last_rdata = rdata;
            tick();
            cyc++;
            if (rready) i++;
        end
        rready = 1'b0;
        chk("r_done", 32'(i > len), 32'd1);
        chk("r_to_arready", 32'({arready, rvalid, rlast}), 32'b100);
        if (mode == 0) chk("r_cycles", 32'(cyc), 32'(len + 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d[$];
        logic [31:0] w0_before;
        logic [31:0] a, b;
        int len, lb;

        // Reset state
        repeat (3) tick();
        chk("rst_outputs", 32'({awready, wready, bvalid, arready, rvalid, rlast}), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_release_ready", 32'({awready, arready}), 32'b11);

        // Fill the whole array so every later read has a known expectation.
        d = {};
        for (int i = 0; i < int'(DEPTH); i++) d.push_back($urandom);
        do_write(32'h0, DEPTH, d);

        // Single beat write then read.
        d = {32'hDEADBEEF};
        do_write(32'h10, 1, d);
        do_read(32'h10, 0, 0);
        chk("single_readback", last_rdata, 32'hDEADBEEF);

        // 16-beat burst, read back with rready high and with stalls.
        d = {};
        for (int i = 0; i < 16; i++) d.push_back(32'(i));
        do_write(32'h0, 16, d);
        do_read(32'h0, 15, 0);
        chk("burst_last_word", last_rdata, 32'd15);
        do_read(32'h0, 15, 1);

        // Two beats starting at the last word.
        w0_before = model_mem[0];
        d = {32'hA, 32'hB};
        do_write(32'((DEPTH - 1) * 4), 2, d);
        do_read(32'h0, 0, 0);
`ifdef AXI_MEM_RESP_ERR_EN
        chk("wrap_word0", last_rdata, w0_before);
`else
        chk("wrap_word0", last_rdata, 32'hB);
`endif
        do_read(32'((DEPTH - 1) * 4), 0, 0);
        chk("wrap_last_word", last_rdata, 32'hA);

        // Reset in the middle of an 8-beat read.
        d = {};
        for (int i = 0; i < 8; i++) d.push_back($urandom);
        do_write(32'h100, 8, d);
        araddr = 32'h100; arlen = 8'd7; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        rready = 1'b1;
        repeat (3) tick();
        chk("mid_burst_rvalid", 32'(rvalid), 32'd1);
        rst = 1'b1;
        tick();
        rready = 1'b0;
        chk("mid_rst_outputs", 32'({rvalid, arready, awready, wready, bvalid, rlast}), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'({arready, awready}), 32'b11);
        do_read(32'h100, 7, 0);

        // Concurrent write and read to disjoint regions.
        for (int k = 0; k < 4; k++) begin
            len = $urandom_range(1, 16);
            lb  = $urandom_range(1, 16);
            a   = 32'($urandom_range(0, 100) * 4);
            b   = 32'($urandom_range(128, 200) * 4);
            d = {};
            for (int i = 0; i < len; i++) d.push_back($urandom);
            fork
                do_write(a, len, d);
                do_read(b, lb - 1, 0);
            join
        end

        // Random mix of writes and reads, addresses may leave the array.
        for (int k = 0; k < 30; k++) begin
            len = $urandom_range(1, 16);
            a   = 32'($urandom_range(0, 4 * DEPTH + 60));
            if ($urandom_range(1) == 0) begin
                d = {};
                for (int i = 0; i < len; i++) d.push_back($urandom);
                do_write(a, len, d);
            end else begin
                do_read(a, len - 1, 2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
